// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the two writeback requesters, the arbiter and the register-file ports.
// Handshake: a transfer happens in a cycle where valid && ready; a requester seeing valid && !ready
// must keep valid, reg and data unchanged until ready, and may drop valid the cycle after a transfer.
interface rf_wb_arbiter_if;
  logic        flush;
  logic        a_valid;
  logic [2:0]  a_reg;
  logic [15:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [2:0]  b_reg;
  logic [15:0] b_data;
  logic        b_ready;
  logic        write;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic [2:0]  read1regsel;
  logic [2:0]  read2regsel;
  logic [15:0] rf_read1data;
  logic [15:0] rf_read2data;
  logic [15:0] read1data;
  logic [15:0] read2data;
  logic        err;

  modport slave (
    input  flush, a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  read1regsel, read2regsel, rf_read1data, rf_read2data,
    output a_ready, b_ready, write, writeregsel, writedata,
    output read1data, read2data, err
  );

  modport master (
    output flush, a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output read1regsel, read2regsel, rf_read1data, rf_read2data,
    input  a_ready, b_ready, write, writeregsel, writedata,
    input  read1data, read2data, err
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register-file write port (ALU port A, load port B), with a
// one-cycle registered write, read-side bypass of that write and a sticky protocol error flag.
module rf_wb_arbiter (
  input  logic              clk,
  input  logic              rst,
  rf_wb_arbiter_if.slave    bus
);

  typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;

  grant_e      last_grant_q, last_grant_d;
  logic        write_q, write_d;
  logic [2:0]  wsel_q, wsel_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        a_wait_q, a_wait_d;
  logic        b_wait_q, b_wait_d;
  logic [2:0]  a_reg_q, b_reg_q;
  logic [15:0] a_data_q, b_data_q;
  logic        a_ready, b_ready;
  logic        a_viol, b_viol;

  // Same destination register forces A first so the older result cannot overwrite the newer one.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rst && !bus.flush) begin
      if (bus.a_valid && bus.b_valid) begin
        if (bus.a_reg == bus.b_reg || last_grant_q == GRANT_B) a_ready = 1'b1;
        else                                                   b_ready = 1'b1;
      end else if (bus.a_valid) begin
        a_ready = 1'b1;
      end else if (bus.b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    write_d      = 1'b0;
    wsel_d       = wsel_q;
    wdata_d      = wdata_q;
    if (a_ready) begin
      last_grant_d = GRANT_A;
      write_d      = 1'b1;
      wsel_d       = bus.a_reg;
      wdata_d      = bus.a_data;
    end else if (b_ready) begin
      last_grant_d = GRANT_B;
      write_d      = 1'b1;
      wsel_d       = bus.b_reg;
      wdata_d      = bus.b_data;
    end
  end

  // A port left waiting last cycle must present the identical request now.
  always_comb begin
    a_viol   = a_wait_q && (!bus.a_valid || bus.a_reg != a_reg_q || bus.a_data != a_data_q);
    b_viol   = b_wait_q && (!bus.b_valid || bus.b_reg != b_reg_q || bus.b_data != b_data_q);
    err_d    = err_q || a_viol || b_viol;
    a_wait_d = bus.a_valid && !a_ready;
    b_wait_d = bus.b_valid && !b_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= GRANT_B;
      write_q      <= 1'b0;
      wsel_q       <= 3'd0;
      wdata_q      <= 16'd0;
      err_q        <= 1'b0;
      a_wait_q     <= 1'b0;
      b_wait_q     <= 1'b0;
      a_reg_q      <= 3'd0;
      b_reg_q      <= 3'd0;
      a_data_q     <= 16'd0;
      b_data_q     <= 16'd0;
    end else begin
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      wsel_q       <= wsel_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      a_wait_q     <= a_wait_d;
      b_wait_q     <= b_wait_d;
      a_reg_q      <= bus.a_reg;
      b_reg_q      <= bus.b_reg;
      a_data_q     <= bus.a_data;
      b_data_q     <= bus.b_data;
    end
  end

  assign bus.a_ready     = a_ready;
  assign bus.b_ready     = b_ready;
  assign bus.write       = write_q;
  assign bus.writeregsel = wsel_q;
  assign bus.writedata   = wdata_q;
  assign bus.err         = err_q;
  assign bus.read1data   = (write_q && wsel_q == bus.read1regsel) ? wdata_q : bus.rf_read1data;
  assign bus.read2data   = (write_q && wsel_q == bus.read2regsel) ? wdata_q : bus.rf_read2data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter: a per-cycle reference model predicts grants,
// bypass data and err, and queues the expected registered write for an independent monitor.
module tb_rf_wb_arbiter;
  localparam int W = 20;

  logic clk;
  logic rst;
  rf_wb_arbiter_if bus ();

  rf_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;
  logic [W-1:0] exp_q[$];

  // model state: registered write on the outputs, last winner, waiting ports, err
  logic        m_we, m_last_b, m_err;
  logic [2:0]  m_sel;
  logic [15:0] m_data;
  logic        m_a_wait, m_b_wait;
  logic [2:0]  m_a_reg, m_b_reg;
  logic [15:0] m_a_data, m_b_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_we = 1'b0; m_sel = 3'd0; m_data = 16'd0; m_last_b = 1'b1; m_err = 1'b0;
    m_a_wait = 1'b0; m_b_wait = 1'b0;
    m_a_reg = 3'd0; m_b_reg = 3'd0; m_a_data = 16'd0; m_b_data = 16'd0;
  endtask

  // Evaluates the current cycle's inputs (sampled mid-cycle) against the rules.
  task automatic model_step();
    logic ea, eb, viol;
    logic [15:0] exp_r1, exp_r2;
    ea = 1'b0;
    eb = 1'b0;
    if (!bus.flush) begin
      if (bus.a_valid && bus.b_valid) begin
        if (bus.a_reg == bus.b_reg) ea = 1'b1;
        else if (m_last_b)          ea = 1'b1;
        else                        eb = 1'b1;
      end else if (bus.a_valid) ea = 1'b1;
      else if (bus.b_valid)     eb = 1'b1;
    end
    check("a_ready", bus.a_ready, ea);
    check("b_ready", bus.b_ready, eb);
    exp_r1 = (m_we && m_sel == bus.read1regsel) ? m_data : bus.rf_read1data;
    exp_r2 = (m_we && m_sel == bus.read2regsel) ? m_data : bus.rf_read2data;
    check("read1data", bus.read1data, exp_r1);
    check("read2data", bus.read2data, exp_r2);
    check("err", bus.err, m_err);
    viol = (m_a_wait && (!bus.a_valid || bus.a_reg != m_a_reg || bus.a_data != m_a_data)) ||
           (m_b_wait && (!bus.b_valid || bus.b_reg != m_b_reg || bus.b_data != m_b_data));
    m_err = m_err | viol;
    m_a_wait = bus.a_valid && !ea;
    m_b_wait = bus.b_valid && !eb;
    m_a_reg = bus.a_reg; m_a_data = bus.a_data;
    m_b_reg = bus.b_reg; m_b_data = bus.b_data;
    m_we = ea | eb;
    if (ea) begin
      m_sel = bus.a_reg; m_data = bus.a_data; m_last_b = 1'b0;
    end else if (eb) begin
      m_sel = bus.b_reg; m_data = bus.b_data; m_last_b = 1'b1;
    end
    exp_q.push_back({m_we, m_sel, m_data});
  endtask

  // driver
  task automatic cycle(input logic av, input logic [2:0] ar, input logic [15:0] ad,
                       input logic bv, input logic [2:0] br, input logic [15:0] bd,
                       input logic fl, input logic [2:0] r1, input logic [2:0] r2);
    @(posedge clk);
    #1;
    bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
    bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
    bus.flush = fl;
    bus.read1regsel = r1; bus.read2regsel = r2;
    bus.rf_read1data = 16'($urandom);
    bus.rf_read2data = 16'($urandom);
    @(negedge clk);
    model_step();
  endtask

  task automatic idle();
    cycle(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    bus.a_valid = 1'b1; bus.a_reg = 3'd2; bus.a_data = 16'h4321;
    bus.b_valid = 1'b0; bus.flush = 1'b0;
    #1;
    check("rst_write_async", bus.write, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_write", bus.write, 1'b0);
    check("rst_a_ready", bus.a_ready, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_writeregsel", bus.writeregsel, 3'd0);
    check("rst_writedata", bus.writedata, 16'd0);
    bus.a_valid = 1'b0;
    model_reset();
    rst = 1'b1;
    mon_en = 1'b1;
  endtask

  // scoreboard monitor: one expected registered write per cycle
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write", bus.write, e[19]);
        check("writeregsel", bus.writeregsel, e[18:16]);
        check("writedata", bus.writedata, e[15:0]);
      end
    end
  end

  initial begin
    logic av, bv, fl;
    logic [2:0] ar, br;
    logic [15:0] ad, bd;
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.a_valid = 1'b0; bus.a_reg = 3'd0; bus.a_data = 16'd0;
    bus.b_valid = 1'b0; bus.b_reg = 3'd0; bus.b_data = 16'd0;
    bus.read1regsel = 3'd0; bus.read2regsel = 3'd0;
    bus.rf_read1data = 16'd0; bus.rf_read2data = 16'd0;
    model_reset();
    do_reset();

    // single request after reset
    cycle(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'd0, 1'b0, 3'd3, 3'd0);
    // B transfer so last_grant is B before the round-robin run
    cycle(1'b0, 3'd0, 16'd0, 1'b1, 3'd7, 16'h0777, 1'b0, 3'd3, 3'd7);
    // round-robin: expect A, B, A, B
    for (int k = 0; k < 4; k++)
      cycle(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b0, 3'd1, 3'd2);
    // same-register ordering with last_grant=A beforehand
    cycle(1'b1, 3'd0, 16'h0A0A, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 3'd5);
    cycle(1'b1, 3'd5, 16'h00AA, 1'b1, 3'd5, 16'h00BB, 1'b0, 3'd5, 3'd0);
    cycle(1'b0, 3'd0, 16'd0, 1'b1, 3'd5, 16'h00BB, 1'b0, 3'd5, 3'd5);
    cycle(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd5, 3'd1);
    // bypass of a registered BEEF write to reg 4
    cycle(1'b1, 3'd4, 16'hBEEF, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 3'd0);
    cycle(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd4, 3'd6);
    // flush the cycle after a transfer while B is requesting
    cycle(1'b1, 3'd2, 16'h5555, 1'b0, 3'd0, 16'd0, 1'b0, 3'd2, 3'd6);
    cycle(1'b0, 3'd0, 16'd0, 1'b1, 3'd6, 16'h6666, 1'b1, 3'd2, 3'd6);
    cycle(1'b0, 3'd0, 16'd0, 1'b1, 3'd6, 16'h6666, 1'b0, 3'd6, 3'd2);
    idle();

    // randomized, protocol-respecting traffic
    for (int i = 0; i < 400; i++) begin
      if (m_a_wait) begin
        av = bus.a_valid; ar = bus.a_reg; ad = bus.a_data;
      end else begin
        av = ($urandom_range(0, 3) != 0); ar = 3'($urandom_range(0, 3)); ad = 16'($urandom);
      end
      if (m_b_wait) begin
        bv = bus.b_valid; br = bus.b_reg; bd = bus.b_data;
      end else begin
        bv = ($urandom_range(0, 3) != 0); br = 3'($urandom_range(0, 3)); bd = 16'($urandom);
      end
      fl = ($urandom_range(0, 9) == 0);
      cycle(av, ar, ad, bv, br, bd, fl, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 4 && (m_a_wait || m_b_wait); i++)
      cycle(bus.a_valid, bus.a_reg, bus.a_data, bus.b_valid, bus.b_reg, bus.b_data, 1'b0, 3'd0, 3'd0);
    idle();

    // protocol error: B loses, then changes its data
    cycle(1'b1, 3'd1, 16'h0001, 1'b1, 3'd1, 16'h00B0, 1'b0, 3'd1, 3'd0);
    cycle(1'b0, 3'd0, 16'd0, 1'b1, 3'd1, 16'h00B1, 1'b0, 3'd1, 3'd0);
    for (int k = 0; k < 3; k++) idle();
    // transfer just before reset so the pending write is dropped asynchronously
    cycle(1'b1, 3'd3, 16'hCAFE, 1'b0, 3'd0, 16'd0, 1'b0, 3'd3, 3'd0);
    do_reset();
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the single write port of the 8×16-bit register file between two writeback requesters: port A (ALU result, older in program order) and port B (memory load result). Arbitration is round-robin with valid/ready handshakes, and the granted write is registered for one cycle before it reaches the register file. Two read-side bypass muxes forward the registered write to same-cycle readers of the target register. The block sits between the execute/memory stages and the register file write/read ports.

## Interface
- No parameters. Data width is fixed at 16 bits and register select at 3 bits.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low. rst=0 clears all state immediately.
- flush  input  1  synchronous cancel of the registered write and of the current cycle's grant.
- a_valid, b_valid  input  1 each  request valid.
- a_reg, b_reg  input  3 each  destination register.
- a_data, b_data  input  16 each  write data.
- a_ready, b_ready  output  1 each  grant; combinational from the valids, the selects, last_grant and flush.
- write  output  1  register-file write enable (registered).
- writeregsel  output  3  register-file write select (registered).
- writedata  output  16  register-file write data (registered).
- read1regsel, read2regsel  input  3 each  read selects, also driven to the register file.
- rf_read1data, rf_read2data  input  16 each  raw register-file read data.
- read1data, read2data  output  16 each  bypassed read data.
- err  output  1  sticky handshake-protocol violation flag.

## Operation
- **Grant rule (evaluated each cycle):**
  - flush=1: no grant.
  - Only one valid: grant that port.
  - Both valid with a_reg==b_reg: grant A. This is the write-after-write ordering rule and overrides round-robin.
  - Both valid with different registers: grant the port that is not last_grant.
- **Handshake:**
  - A transfer occurs when valid && ready.
  - A requester holding valid without ready must keep valid, reg and data stable until ready.
  - A ready port may drop valid the next cycle.
- **last_grant:**
  - 1-bit flop, updated to the granted port on every transfer.
  - Reset value is B, so A wins the first contention.
- **Write register:**
  - On a transfer, the next cycle drives write=1 with the granted reg and data.
  - With no transfer, or flush=1, the next cycle drives write=0. writeregsel and writedata hold their previous values.
  - flush also clears a registered write in the same edge: the cycle after flush, write=0.
- **Bypass:**
  - read1data = (write && writeregsel==read1regsel) ? writedata : rf_read1data.
  - read2data follows the same rule with read2regsel and rf_read2data.
  - This is purely combinational on the registered write.
- **err:**
  - Set on a clock edge when, in the previous cycle, a port had valid=1 and ready=0, and in the current cycle that port's valid is 0 or its reg/data differ.
  - Once set, err remains 1 until rst.
  - err does not affect arbitration.
- **Reset values:** write=0, writeregsel=0, writedata=0, last_grant=B, err=0. a_ready and b_ready are 0 while rst=0.

## Timing
- Latency is 1 cycle: a request granted in cycle N produces write=1 in cycle N+1, and the register file updates at the end of N+1.
- Throughput is one write per cycle, sustained with no bubbles.
- When both ports are continuously valid to different registers, grants alternate A, B, A, B.
- Worst-case wait for a valid request is 1 cycle (round-robin), except when both ports target the same register: B waits until A's transfer, then wins the following cycle because A has no new request or because of round-robin.
- Asserting rst mid-transfer drops the pending write immediately (write=0, asynchronous). The requester must re-present its request after reset.
- flush and a valid request in the same cycle: ready=0 and no transfer. The requester holds; this is not an err condition.

## Test plan
- **Reset/idle:** hold rst=0 with a_valid=1 → write=0, a_ready=0, err=0. After release, a_valid=1, a_reg=3, a_data=16'h1234 → a_ready=1; the next cycle write=1, writeregsel=3, writedata=16'h1234.
- **Round-robin:** a_valid=b_valid=1 for 4 cycles, a_reg=1, b_reg=2 → grant order A, B, A, B; write sequence regs 1, 2, 1, 2 with no gap cycles.
- **Same-register ordering:** a_reg=b_reg=5, a_data=16'h00AA, b_data=16'h00BB, with last_grant=A beforehand → A granted first, then B. The register file ends holding 16'h00BB.
- **Bypass:** a write of 16'hBEEF to reg 4 is registered; in the same cycle read1regsel=4, read2regsel=6 → read1data=16'hBEEF, read2data=rf_read2data.
- **Flush:** transfer in cycle N, flush=1 in N+1 while b_valid=1 → write=0 in N+2, b_ready=0 in N+1, and B is granted in N+2 if still valid.
- **Protocol error:** b_valid=1 while losing arbitration, then b_data changes the next cycle → err=1 on that edge and stays 1 until rst=0.
